// File: rtl/datapath_pkg.sv
// Shared widths, types and reset constants for the datapath register file.
// No logic; constants only.
// Used by datapath_regfile and regfile_read_port.
package datapath_pkg;

    localparam int BUS_WIDTH  = 16;
    localparam int REG_COUNT  = 8;
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [BUS_WIDTH-1:0]  word_t;

    localparam word_t      WORD_RESET      = '0;
    localparam logic       ZERO_FLAG_RESET = 1'b1;
    localparam logic [7:0] WR_COUNT_MAX    = 8'hFF;

endpackage

// File: rtl/datapath_regfile_read_port.sv
// Purpose: one combinational read port, address mux plus optional write-to-read forwarding.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; with REGFILE_BYPASS_EN a same-cycle write to the read address is forwarded.
module regfile_read_port
    import datapath_pkg::*;
(
    input  word_t     regs_i [REG_COUNT],
    input  reg_addr_t rd_addr_i,
    input  logic      wr_en_i,
    input  reg_addr_t wr_addr_i,
    input  word_t     wr_data_i,
    output word_t     rd_data_o
);

    // Select the stored word, overridden by the in-flight write when forwarding is built in.
    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end
`endif
    end

`ifndef REGFILE_BYPASS_EN
    // Write-port inputs only matter when forwarding is enabled.
    logic unused_wr_sink;
    assign unused_wr_sink = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

endmodule

// File: rtl/datapath_regfile.sv
// Purpose: architectural register file, 2 combinational read ports, 1 write port, registered zero flag.
// Latency: reads 0 cycles; writes visible after the next rising edge (same cycle if REGFILE_BYPASS_EN).
// Backpressure: none; every wr_en cycle commits. Optional macro: REGFILE_BYPASS_EN.
module datapath_regfile
    import datapath_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]  wr_data,
    input  logic                  zero_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [BUS_WIDTH-1:0]  data_a,
    output logic [BUS_WIDTH-1:0]  data_b,
    output logic                  zero_flag,
    output logic [7:0]            wr_count
);

    word_t      regs_q [REG_COUNT];
    word_t      regs_d [REG_COUNT];
    logic       zero_flag_q, zero_flag_d;
    logic [7:0] wr_count_q, wr_count_d;

    // Next state: write decode, zero flag capture and saturating write counter.
    always_comb begin
        regs_d      = regs_q;
        zero_flag_d = zero_flag_q;
        wr_count_d  = wr_count_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            zero_flag_d     = zero_in;
            if (wr_count_q != WR_COUNT_MAX) begin
                wr_count_d = wr_count_q + 8'd1;
            end
        end
    end

    // State registers; asynchronous reset wins over any write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= WORD_RESET;
            end
            zero_flag_q <= ZERO_FLAG_RESET;
            wr_count_q  <= '0;
        end else begin
            regs_q      <= regs_d;
            zero_flag_q <= zero_flag_d;
            wr_count_q  <= wr_count_d;
        end
    end

    regfile_read_port u_port_a (
        .regs_i    (regs_q),
        .rd_addr_i (rd_addr_a),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (data_a)
    );

    regfile_read_port u_port_b (
        .regs_i    (regs_q),
        .rd_addr_i (rd_addr_b),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_data_o (data_b)
    );

    assign zero_flag = zero_flag_q;
    assign wr_count  = wr_count_q;

endmodule
